// File: rtl/mr_wb_arb.sv
// Two-master pipelined Wishbone B4 arbiter: ifetch (m0) and ldst (m1) share one slave.
// Fair tie-break on last grant, outstanding-transfer tracking, grant held until responses drain.
module mr_wb_arb #(
    parameter int ADR_W     = 30,
    parameter int DAT_W     = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADR_W-1:0]     m0_adr_i,
    input  logic [DAT_W-1:0]     m0_dat_i,
    output logic [DAT_W-1:0]     m0_dat_o,
    input  logic                 m0_we_i,
    input  logic [DAT_W/8-1:0]   m0_sel_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_cyc_i,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    output logic                 m0_stall_o,
    input  logic [ADR_W-1:0]     m1_adr_i,
    input  logic [DAT_W-1:0]     m1_dat_i,
    output logic [DAT_W-1:0]     m1_dat_o,
    input  logic                 m1_we_i,
    input  logic [DAT_W/8-1:0]   m1_sel_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_cyc_i,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 m1_stall_o,
    output logic [ADR_W-1:0]     s_adr_o,
    output logic [DAT_W-1:0]     s_dat_o,
    input  logic [DAT_W-1:0]     s_dat_i,
    output logic                 s_we_o,
    output logic [DAT_W/8-1:0]   s_sel_o,
    output logic                 s_stb_o,
    output logic                 s_cyc_o,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic                 s_stall_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic [3:0] MAX_Q = 4'(MAX_OUTST);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  outst_q, outst_d;

    logic        own0_s, own1_s, own_cyc_s, own_stb_s;
    logic        full_s, rsp_ok_s, accept_s, resp_s;

    // State, last-grant and outstanding-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            outst_q <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            last_q  <= last_d;
        end
    end

    // Owner decode; responses only count when a transfer is actually pending.
    always_comb begin
        own0_s = (state_q == ST_OWN0);
        own1_s = (state_q == ST_OWN1);
        if (own0_s) begin
            own_cyc_s = m0_cyc_i;
            own_stb_s = m0_stb_i;
        end else if (own1_s) begin
            own_cyc_s = m1_cyc_i;
            own_stb_s = m1_stb_i;
        end else begin
            own_cyc_s = 1'b0;
            own_stb_s = 1'b0;
        end
        full_s   = (outst_q >= MAX_Q);
        rsp_ok_s = (own0_s | own1_s) & (outst_q != 4'd0);
    end

    // Outstanding counter and grant next-state; release waits for the count to drain.
    always_comb begin
        accept_s = s_stb_o & ~s_stall_i;
        resp_s   = rsp_ok_s & (s_ack_i | s_err_i);
        case ({accept_s, resp_s})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i && (outst_d == 4'd0)) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? ST_OWN1 : ST_IDLE;
                end else begin
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i && (outst_d == 4'd0)) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? ST_OWN0 : ST_IDLE;
                end else begin
                    state_d = ST_OWN1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b1;
            end
        endcase
    end

    // Unregistered routing so master and slave observe the same stall cycle.
    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        m0_dat_o   = '0;
        m1_dat_o   = '0;
        s_stb_o    = own_cyc_s & own_stb_s & ~full_s;
        s_cyc_o    = (own0_s | own1_s) & (own_cyc_s | (outst_q != 4'd0));
        m0_ack_o   = own0_s & rsp_ok_s & s_ack_i;
        m0_err_o   = own0_s & rsp_ok_s & s_err_i;
        m1_ack_o   = own1_s & rsp_ok_s & s_ack_i;
        m1_err_o   = own1_s & rsp_ok_s & s_err_i;
        m0_stall_o = own0_s ? (s_stall_i | full_s) : 1'b1;
        m1_stall_o = own1_s ? (s_stall_i | full_s) : 1'b1;
        case (state_q)
            ST_OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
            end
            ST_OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
            end
            default: begin
                s_we_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Self-checking bench for mr_wb_arb: reset vectors, a hand-derived table, directed
// multi-cycle scenarios and random traffic against a transaction-level arbiter model.
module tb_mr_wb_arb;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o, m0_stall_o;
    logic m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o, m1_stall_o;
    logic s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_stall_i;

    always #5 clk = ~clk;

    mr_wb_arb #(.ADR_W(AW), .DAT_W(DW), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .s_stall_i(s_stall_i)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: owner (-1 none), pending transfer count, last released master.
    int m_owner, m_outst, m_last;
    bit m_acc;
    int cyc_n = 0;

    // Directed-sequence helpers: bench-side master/slave behaviour.
    bit auto_mst = 1'b0, auto_slave = 1'b0;
    bit hold0 = 1'b0, hold1 = 1'b0;
    int rem0 = 0, rem1 = 0, ack_dly = 1;
    int pend[$];
    int acc_before, ack0_cnt, ack1_cnt, ack0_bad, drain_bad;

    typedef struct packed {
        logic c0, s0, c1, s1, st, ak;
        logic [5:0] exp;  // {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_slv"}, {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, 128'd0);
        chk({nm, "_mst"}, {m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o}, 128'd9);
        chk({nm, "_dat"}, {m0_dat_o, m1_dat_o}, 128'd0);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_outst = 0;
        m_last  = 1;
    endtask

    task automatic clear_cnt();
        acc_before = 0; ack0_cnt = 0; ack1_cnt = 0; ack0_bad = 0; drain_bad = 0;
    endtask

    // Predict this cycle's outputs from the model, compare, then advance the model.
    task automatic model_step();
        int o, nxt;
        logic own, ocyc, ostb, e_scyc, e_sstb, valid;
        logic [68:0] e_slv;
        logic [5:0] e_m;
        logic [63:0] e_d;
        o = m_owner;
        own = (o >= 0);
        ocyc = (o == 0) ? m0_cyc_i : ((o == 1) ? m1_cyc_i : 1'b0);
        ostb = (o == 0) ? m0_stb_i : ((o == 1) ? m1_stb_i : 1'b0);
        e_scyc = own && (ocyc || (m_outst > 0));
        e_sstb = own && ocyc && ostb && (m_outst < MAXO);
        if (o == 0) e_slv = {e_scyc, e_sstb, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
        else if (o == 1) e_slv = {e_scyc, e_sstb, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
        else e_slv = 69'd0;
        valid = own && (m_outst > 0);
        e_m = {(o == 0) && valid && s_ack_i, (o == 0) && valid && s_err_i,
               (o == 0) ? (s_stall_i || (m_outst == MAXO)) : 1'b1,
               (o == 1) && valid && s_ack_i, (o == 1) && valid && s_err_i,
               (o == 1) ? (s_stall_i || (m_outst == MAXO)) : 1'b1};
        e_d = own ? {s_dat_i, s_dat_i} : 64'd0;
        chk("slave_bus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, e_slv);
        chk("master_hs", {m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o}, e_m);
        chk("rd_data", {m0_dat_o, m1_dat_o}, e_d);

        m_acc = e_sstb && !s_stall_i;
        if (m_acc && auto_mst) begin
            if (o == 0) rem0--; else rem1--;
        end
        nxt = m_outst + (m_acc ? 1 : 0) - ((valid && (s_ack_i || s_err_i)) ? 1 : 0);
        if (!own) begin
            if (m0_cyc_i && m1_cyc_i) m_owner = (m_last == 0) ? 1 : 0;
            else if (m0_cyc_i) m_owner = 0;
            else if (m1_cyc_i) m_owner = 1;
        end else if (!ocyc && nxt == 0) begin
            m_last = o;
            m_owner = ((o == 0) ? m1_cyc_i : m0_cyc_i) ? 1 - o : -1;
        end
        m_outst = nxt;
    endtask

    // One bus cycle: inputs set at posedge+1, compare mid-cycle, advance to next posedge+1.
    task automatic do_cycle();
        if (auto_mst) begin
            m0_stb_i = (rem0 > 0);
            m0_cyc_i = hold0 || (rem0 > 0);
            m1_stb_i = (rem1 > 0);
            m1_cyc_i = hold1 || (rem1 > 0);
            m0_adr_i = 30'($urandom());
            m1_adr_i = 30'($urandom());
            s_dat_i  = $urandom();
        end
        if (auto_slave) begin
            s_ack_i = 1'b0;
            if (pend.size() > 0 && pend[0] == cyc_n) begin
                s_ack_i = 1'b1;
                void'(pend.pop_front());
            end
        end
        #2;
        if (s_stb_o && !s_stall_i && ack0_cnt == 0 && !m0_ack_o) acc_before++;
        if (m0_ack_o) begin
            ack0_cnt++;
            if (m_owner == 1) ack0_bad++;
        end
        if (m1_ack_o) ack1_cnt++;
        if (m_owner == 1 && !m0_stall_o) ack0_bad++;
        if (m_owner == 0 && !m0_cyc_i && m_outst > 0 && (!s_cyc_o || s_stb_o)) drain_bad++;
        model_step();
        if (auto_slave && m_acc) pend.push_back(cyc_n + ack_dly);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001100};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110100};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b100110};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000100};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b111000};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111100};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b101000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b101001};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001100};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001000};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001100};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100};

        // Busy inputs during reset so any ungated passthrough would show.
        rst = 1'b0;
        m0_adr_i = 30'h1234567; m0_dat_i = 32'hCAFE0001; m0_we_i = 1'b1; m0_sel_i = 4'hF;
        m0_stb_i = 1'b1; m0_cyc_i = 1'b1;
        m1_adr_i = 30'h0ABCDEF; m1_dat_i = 32'hCAFE0002; m1_we_i = 1'b1; m1_sel_i = 4'h3;
        m1_stb_i = 1'b1; m1_cyc_i = 1'b1;
        s_dat_i = 32'hDEADBEEF; s_ack_i = 1'b1; s_err_i = 1'b1; s_stall_i = 1'b0;
        model_reset();
        clear_cnt();
        #12;
        chk_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_err_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            m0_cyc_i = tbl[i].c0; m0_stb_i = tbl[i].s0;
            m1_cyc_i = tbl[i].c1; m1_stb_i = tbl[i].s1;
            s_stall_i = tbl[i].st; s_ack_i = tbl[i].ak;
            m0_adr_i = 30'($urandom()); m1_adr_i = 30'($urandom());
            #2;
            chk($sformatf("vec%0d", i),
                {s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o}, tbl[i].exp);
            do_cycle();
        end

        // Six back-to-back strobes, ack four cycles after acceptance, window of four.
        clear_cnt();
        auto_mst = 1'b1; auto_slave = 1'b1; ack_dly = 4;
        s_stall_i = 1'b0; s_err_i = 1'b0;
        rem0 = 6;
        run(20);
        chk("accepts_before_first_ack", acc_before, 4);
        chk("m0_total_acks", ack0_cnt, 6);

        // m1 keeps the bus for ten transfers while m0 waits.
        clear_cnt();
        ack_dly = 2;
        rem1 = 10;
        run(1);
        rem0 = 2;
        run(40);
        chk("m0_blocked_while_m1_owns", ack0_bad, 0);
        chk("m1_total_acks", ack1_cnt, 10);
        chk("m0_acks_after_handover", ack0_cnt, 2);

        // Owner drops cyc with two transfers in flight; m1 waits for the drain.
        clear_cnt();
        ack_dly = 5;
        rem0 = 2;
        run(1);
        hold1 = 1'b1;
        run(12);
        hold1 = 1'b0;
        run(4);
        chk("drain_cyc_hold_stb_low", drain_bad, 0);
        chk("drain_acks_to_m0", ack0_cnt, 2);
        chk("no_acks_to_m1", ack1_cnt, 0);

        // Spurious responses while idle, then a normal transfer.
        clear_cnt();
        auto_slave = 1'b0;
        s_ack_i = 1'b1; s_err_i = 1'b1;
        run(3);
        s_ack_i = 1'b0; s_err_i = 1'b0;
        chk("spurious_ack_dropped", ack0_cnt + ack1_cnt, 0);
        auto_slave = 1'b1; ack_dly = 1;
        rem0 = 1;
        run(6);
        chk("ack_after_spurious", ack0_cnt, 1);

        // Reset with three transfers outstanding on m1.
        ack_dly = 50;
        rem1 = 3; hold1 = 1'b1;
        run(6);
        s_dat_i = 32'hA5A55A5A;
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        pend.delete();
        rem0 = 0; rem1 = 0; hold0 = 1'b0; hold1 = 1'b0;
        auto_mst = 1'b0; auto_slave = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset("rst_held");
        rst = 1'b1;
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1; m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i = 1'b1;
        do_cycle();
        #2;
        chk("tie_after_reset_to_m0", {m0_stall_o, m1_stall_o, m0_ack_o}, 3'b010);
        do_cycle();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        run(3);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            m0_cyc_i = ($urandom_range(0, 3) != 0);
            m1_cyc_i = ($urandom_range(0, 3) != 0);
            m0_stb_i = ($urandom_range(0, 3) != 0);
            m1_stb_i = ($urandom_range(0, 3) != 0);
            m0_we_i = 1'($urandom_range(0, 1));
            m1_we_i = 1'($urandom_range(0, 1));
            m0_sel_i = 4'($urandom());
            m1_sel_i = 4'($urandom());
            m0_adr_i = 30'($urandom());
            m1_adr_i = 30'($urandom());
            m0_dat_i = $urandom();
            m1_dat_i = $urandom();
            s_dat_i = $urandom();
            s_stall_i = ($urandom_range(0, 3) == 0);
            s_ack_i = ($urandom_range(0, 3) == 0);
            s_err_i = ($urandom_range(0, 9) == 0);
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mr_wb_arb.md
MR_WB_ARB -- requirements
Module: mr_wb_arb

Interface
REQ-001 SHALL have parameter ADR_W, default 30, word-address width (XLEN-XLEN_GRAN).
REQ-002 SHALL have parameter DAT_W, default 32, data width; SEL width is DAT_W/8.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum accepted-but-unacknowledged slave transfers (range 1..15).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = in reset), synchronous deassert by integrator.
REQ-006 mN_adr_i  in  ADR_W  master N address, N in {0 = ifetch, 1 = ldst}.
REQ-007 mN_dat_i  in  DAT_W  master N write data.
REQ-008 mN_dat_o  out  DAT_W  master N read data.
REQ-009 mN_we_i  in  1  master N write enable.
REQ-010 mN_sel_i  in  DAT_W/8  master N byte select.
REQ-011 mN_stb_i  in  1  master N strobe.
REQ-012 mN_cyc_i  in  1  master N cycle / bus request.
REQ-013 mN_ack_o  out  1  master N acknowledge.
REQ-014 mN_err_o  out  1  master N error.
REQ-015 mN_stall_o  out  1  master N stall (pipelined Wishbone B4).
REQ-016 s_adr_o  out  ADR_W  slave address.
REQ-017 s_dat_o  out  DAT_W  slave write data.
REQ-018 s_dat_i  in  DAT_W  slave read data.
REQ-019 s_we_o  out  1  slave write enable.
REQ-020 s_sel_o  out  DAT_W/8  slave byte select.
REQ-021 s_stb_o  out  1  slave strobe.
REQ-022 s_cyc_o  out  1  slave cycle.
REQ-023 s_ack_i  in  1  slave acknowledge.
REQ-024 s_err_i  in  1  slave error.
REQ-025 s_stall_i  in  1  slave stall.

Function
REQ-026 SHALL implement states IDLE, OWN0, OWN1, plus registered last-grant bit `last` and outstanding counter `outst`, which is 4 bits wide.
REQ-027 In IDLE the block SHALL arbitrate as follows. If exactly one mN_cyc_i=1, go to OWNN next cycle. If both are 1, grant the master != last. One-cycle grant latency.
REQ-028 In OWNN the block SHALL drive s_adr_o, s_dat_o, s_we_o and s_sel_o from master N. s_dat_i SHALL feed both mN_dat_o.
REQ-029 In OWNN the block SHALL set s_stb_o = mN_stb_i & (outst < MAX_OUTST).
REQ-030 In OWNN the block SHALL set mN_stall_o = s_stall_i | (outst == MAX_OUTST).
REQ-031 The non-owner, and both masters in IDLE, SHALL see stall_o=1, ack_o=0 and err_o=0. s_stb_o and s_cyc_o SHALL be 0 in IDLE, and s_adr/dat/sel/we SHALL be 0 in IDLE.
REQ-032 s_cyc_o SHALL equal owner cyc_i | (outst != 0).
REQ-033 mN_ack_o and mN_err_o SHALL equal s_ack_i and s_err_i combinationally, for the owner only.
REQ-034 outst SHALL be updated as follows:
- increment on accept (s_stb_o & ~s_stall_i);
- decrement on s_ack_i | s_err_i;
- both in the same cycle leaves it unchanged.
REQ-035 An ack or err with outst==0 SHALL be dropped, not forwarded, and outst SHALL stay 0 (no wrap).
REQ-036 Release condition SHALL be: owner cyc_i=0 and outst-next == 0. The owner SHALL keep the grant while its cyc_i=1, even if the other master requests.
REQ-037 On release from OWNN, last SHALL be set to N. Next state SHALL be OWN(1-N) if m(1-N)_cyc_i=1, else IDLE. There is no idle bubble on handover.
REQ-038 If the owner drops cyc_i with outst>0, the block SHALL hold the grant. s_stb_o SHALL be 0 until the remaining acks/errs drain, and those SHALL still be routed to the former owner.
REQ-039 A stalled strobe SHALL NOT be counted. Master address/data SHALL pass through unregistered, so master and slave see the same stall cycle.

Reset
REQ-040 While rst=0 the block SHALL force:
- state=IDLE, outst=0, last=1 (master 0 wins the first tie);
- s_stb_o=0, s_cyc_o=0, s_we_o=0;
- s_adr/dat/sel=0;
- mN_ack_o=0, mN_err_o=0, mN_stall_o=1, mN_dat_o=0.
REQ-041 Reset asserted mid-transfer SHALL abandon the outstanding count immediately. No ack SHALL be forwarded after reset until a new grant is issued.

Verification
REQ-042 Reset, then m0_cyc=m1_cyc=1 in the same cycle -> OWN0 one cycle later. After m0 releases with outst=0 -> OWN1 on the next edge.
REQ-043 Slave s_stall_i=0 and ack delayed 3 cycles; owner issues 6 stb back-to-back with MAX_OUTST=4 -> 4 accepted, then mN_stall_o=1 until the first ack. outst never exceeds 4 and returns to 0.
REQ-044 m1 holds cyc=1 for 10 transfers while m0 requests -> m0_stall_o=1 and m0_ack_o=0 throughout. m0 is granted on the cycle after m1's cyc drops and the final ack arrives.
REQ-045 Owner drops cyc with outst=2 -> s_cyc_o stays 1 and s_stb_o=0, the 2 acks are routed to that owner, then handover. A spurious s_ack_i in IDLE -> no mN_ack_o and outst stays 0.
REQ-046 rst=0 asserted with outst=3 in OWN1 -> outputs reach reset values asynchronously. After release, the first grant goes to m0 on a tie.
